// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and constants for the unified memory arbiter.
// Imported by the arbiter top and its latency counter.
package unified_mem_arbiter_pkg;

    localparam int WORD_SIZE = 16;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/unified_mem_arbiter_latency_counter.sv
// Loadable down-counter with a zero flag.
// Shared by the arbiter and the cache fill controller.
module latency_counter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Serialises instruction and data requests onto one
// fixed-latency single-ported memory, data first.
module unified_mem_arbiter #(
    parameter int WORD_SIZE = unified_mem_arbiter_pkg::WORD_SIZE,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic                 i_ack,
    output logic [WORD_SIZE-1:0] i_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic                 d_ack,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata
);

    import unified_mem_arbiter_pkg::*;

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

    state_t               state_q;
    state_t               state_d;
    logic                 grant;
    logic                 cnt_zero;
    logic                 busy;
    logic                 owner_q;
    logic                 we_q;
    logic [WORD_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic [WORD_SIZE-1:0] i_rdata_q;
    logic [WORD_SIZE-1:0] d_rdata_q;

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (d_req || i_req) begin
                    state_d = ST_BUSY;
                    grant   = 1'b1;
                end
            end
            ST_BUSY: begin
                if (cnt_zero) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q == ST_BUSY);

    latency_counter #(.WIDTH(CNT_W)) u_cnt (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_i    (grant),
        .load_val_i(LOAD_VAL),
        .dec_i     (busy),
        .zero_o    (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Write transactions leave both read-data registers untouched.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            owner_q   <= OWN_I;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if (grant) begin
                owner_q <= d_req ? OWN_D : OWN_I;
                we_q    <= d_req & d_we;
                addr_q  <= d_req ? d_addr : i_addr;
                wdata_q <= d_req ? d_wdata : '0;
            end
            if (busy && cnt_zero && !we_q) begin
                if (owner_q == OWN_D) begin
                    d_rdata_q <= mem_rdata;
                end else begin
                    i_rdata_q <= mem_rdata;
                end
            end
        end
    end

    assign mem_read  = busy & ~we_q;
    assign mem_write = busy & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_ack     = (state_q == ST_RESP) & (owner_q == OWN_I);
    assign d_ack     = (state_q == ST_RESP) & (owner_q == OWN_D);
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter at LATENCY 2 and 1.
// Inputs change 1ns after posedge; outputs sampled there too.
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;

    logic        i_req, d_req, d_we;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        i_ack, d_ack, mem_read, mem_write;
    logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        l_i_req, l_d_req, l_d_we;
    logic [15:0] l_i_addr, l_d_addr, l_d_wdata;
    logic        l_i_ack, l_d_ack, l_mem_read, l_mem_write;
    logic [15:0] l_i_rdata, l_d_rdata, l_mem_addr, l_mem_wdata;
    logic [15:0] l_mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [256];
    logic        mem_init_done = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
            mem[8'h10] <= 16'h6001;
            mem[8'h11] <= 16'h6002;
            mem[8'h40] <= 16'h7000;
            mem[8'h41] <= 16'h7001;
            mem[8'h42] <= 16'h7002;
            mem[8'h43] <= 16'h7003;
            mem_init_done <= 1'b1;
        end else if (mem_write) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end
    end

    assign mem_rdata   = mem[mem_addr[7:0]];
    assign l_mem_rdata = l_mem_addr ^ 16'hA5A5;

    unified_mem_arbiter #(.WORD_SIZE(16), .LATENCY(2)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr),
        .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we),
        .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    unified_mem_arbiter #(.WORD_SIZE(16), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .reset_n(reset_n),
        .i_req(l_i_req), .i_addr(l_i_addr),
        .i_ack(l_i_ack), .i_rdata(l_i_rdata),
        .d_req(l_d_req), .d_we(l_d_we),
        .d_addr(l_d_addr), .d_wdata(l_d_wdata),
        .d_ack(l_d_ack), .d_rdata(l_d_rdata),
        .mem_read(l_mem_read), .mem_write(l_mem_write),
        .mem_addr(l_mem_addr), .mem_wdata(l_mem_wdata),
        .mem_rdata(l_mem_rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        i_req = 0; d_req = 0; d_we = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0;
        l_i_req = 0; l_d_req = 0; l_d_we = 0;
        l_i_addr = 0; l_d_addr = 0; l_d_wdata = 0;
        step();
        step();
        chk("rst_rd", mem_read, 0);
        chk("rst_wr", mem_write, 0);
        chk("rst_iack", i_ack, 0);
        chk("rst_dack", d_ack, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_irdata", i_rdata, 0);
        chk("rst_drdata", d_rdata, 0);
        reset_n = 1'b1;

        // single fetch
        step();
        i_req = 1; i_addr = 16'h0010;
        step();
        chk("t1_rd1", mem_read, 1);
        chk("t1_addr1", mem_addr, 16'h0010);
        chk("t1_ack_b1", i_ack, 0);
        step();
        chk("t1_rd2", mem_read, 1);
        chk("t1_ack_b2", i_ack, 0);
        step();
        chk("t1_ack", i_ack, 1);
        chk("t1_rdata", i_rdata, 16'h6001);
        chk("t1_rd_resp", mem_read, 0);
        i_req = 0;
        step();
        chk("t1_ack_once", i_ack, 0);

        // data write then read-back
        d_req = 1; d_we = 1; d_addr = 16'h0020; d_wdata = 16'hBEEF;
        step();
        chk("t2_wr1", mem_write, 1);
        chk("t2_rd1", mem_read, 0);
        chk("t2_wdata", mem_wdata, 16'hBEEF);
        step();
        chk("t2_wr2", mem_write, 1);
        step();
        chk("t2_wack", d_ack, 1);
        chk("t2_wr_resp", mem_write, 0);
        chk("t2_drdata_keep", d_rdata, 0);
        d_we = 0;
        step();
        chk("t2_idle_ack", d_ack, 0);
        step();
        chk("t2_rd", mem_read, 1);
        chk("t2_raddr", mem_addr, 16'h0020);
        step();
        chk("t2_rack_early", d_ack, 0);
        step();
        chk("t2_rack", d_ack, 1);
        chk("t2_rdata", d_rdata, 16'hBEEF);
        d_req = 0;

        // simultaneous requests: D wins
        step();
        d_req = 1; d_we = 1; d_addr = 16'h0030; d_wdata = 16'h1234;
        i_req = 1; i_addr = 16'h0011;
        for (int c = 1; c <= 7; c++) begin
            step();
            chk("t3_excl", {31'd0, mem_read & mem_write}, 0);
            chk("t3_dack", d_ack, (c == 3));
            chk("t3_iack", i_ack, (c == 7));
            if (c == 1) chk("t3_first_wr", mem_write, 1);
            if (c == 3) d_req = 0;
            if (c == 5) chk("t3_iaddr", mem_addr, 16'h0011);
            if (c == 7) begin
                chk("t3_irdata", i_rdata, 16'h6002);
                i_req = 0;
            end
        end

        // continuous fetch stream, next address presented after ack
        for (int k = 0; k < 4; k++) begin
            step();
            i_req = 1; i_addr = 16'h0040 + 16'(k);
            step();
            chk("t4_addr_b1", mem_addr, 16'h0040 + 16'(k));
            chk("t4_rd_b1", mem_read, 1);
            chk("t4_ack_b1", i_ack, 0);
            step();
            chk("t4_addr_b2", mem_addr, 16'h0040 + 16'(k));
            chk("t4_ack_b2", i_ack, 0);
            step();
            chk("t4_ack", i_ack, 1);
            chk("t4_rdata", i_rdata, 16'h7000 + 16'(k));
        end
        i_req = 0;

        // reset in the second BUSY cycle of a write
        step();
        d_req = 1; d_we = 1; d_addr = 16'h0050; d_wdata = 16'h5555;
        step();
        chk("t5_wr1", mem_write, 1);
        step();
        chk("t5_wr2", mem_write, 1);
        reset_n = 1'b0;
        step();
        chk("t5_wr", mem_write, 0);
        chk("t5_rd", mem_read, 0);
        chk("t5_addr", mem_addr, 0);
        chk("t5_wdata", mem_wdata, 0);
        chk("t5_dack", d_ack, 0);
        chk("t5_iack", i_ack, 0);
        chk("t5_irdata", i_rdata, 0);
        chk("t5_drdata", d_rdata, 0);
        reset_n = 1'b1;
        d_req = 0; d_we = 0;
        step();
        chk("t5_no_dack", d_ack, 0);
        chk("t5_no_wr", mem_write, 0);
        i_req = 1; i_addr = 16'h0010;
        step();
        step();
        step();
        chk("t5_iack", i_ack, 1);
        chk("t5_ifetch", i_rdata, 16'h6001);
        i_req = 0;

        // LATENCY=1 instance, simultaneous requests
        step();
        l_d_req = 1; l_d_we = 0; l_d_addr = 16'h0060;
        l_i_req = 1; l_i_addr = 16'h0061;
        for (int c = 1; c <= 5; c++) begin
            step();
            chk("t6_dack", l_d_ack, (c == 2));
            chk("t6_iack", l_i_ack, (c == 5));
            if (c == 1) chk("t6_daddr", l_mem_addr, 16'h0060);
            if (c == 1) chk("t6_drd", l_mem_read, 1);
            if (c == 2) begin
                chk("t6_drdata", l_d_rdata, 16'hA5C5);
                l_d_req = 0;
            end
            if (c == 4) chk("t6_iaddr", l_mem_addr, 16'h0061);
            if (c == 5) begin
                chk("t6_irdata", l_i_rdata, 16'hA5C4);
                l_i_req = 0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
